alu_ctrl_unit: RTL and testbench
================================

ALU_CTRL_UNIT -- requirements
Module: alu_ctrl_unit

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- MODE, 1: 0 = legacy pass-through (alu_ctrl = opcode); 1 = MIPS opcode+funct decode.
- CTRLW, 6: alu_ctrl width, >= 4.
- MDU_CYCLES, 32: multiply/divide occupancy in cycles, >= 1.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- in_valid, in, 1: opcode/funct valid.
- in_ready, out, 1: unit accepts this cycle.
- opcode, in, 6: instruction [31:26].
- funct, in, 6: instruction [5:0].
- flush, in, 1: synchronous pipeline flush.
- out_valid, out, 1: registered decode valid.
- out_ready, in, 1: downstream consumes the output.
- alu_ctrl, out, CTRLW: registered ALU operation code.
- is_mdu, out, 1: registered op is MULT or DIV.
- illegal, out, 1: registered op is undecodable.
- mdu_busy, out, 1: multiply/divide in progress.

Function
REQ-003 Codes SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, MULT=12, DIV=13.
REQ-004 MODE=1, opcode 0x00 SHALL decode funct: 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA; 0x18/0x19 MULT; 0x1A/0x1B DIV.
REQ-005 MODE=1, opcode != 0x00 SHALL decode: 0x08/0x09/0x23/0x2B ADD; 0x04/0x05 SUB; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0A SLT; 0x0B SLTU; 0x0F LUI; funct ignored.
REQ-006 MODE=1 unlisted encodings SHALL register alu_ctrl=0, illegal=1, is_mdu=0.
REQ-007 MODE=0 SHALL register alu_ctrl = opcode zero-extended/truncated to CTRLW, illegal=0, is_mdu=0, and never enter BUSY.
REQ-008 Accept SHALL occur iff in_valid && in_ready && !flush.
REQ-009 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready), combinational.
REQ-010 Latency SHALL be 1 cycle: decode for an op accepted in cycle t appears with out_valid=1 in cycle t+1.
REQ-011 out_valid && !out_ready SHALL hold alu_ctrl, is_mdu, illegal, out_valid stable.
REQ-012 out_valid && out_ready without accept SHALL clear out_valid next cycle; with accept it SHALL load the new decode (back-to-back, 1 op/cycle).
REQ-013 FSM SHALL have states IDLE and BUSY with a counter of width clog2(MDU_CYCLES+1).
REQ-014 IDLE -> BUSY SHALL occur on accept of a MULT or DIV op, loading counter=MDU_CYCLES.
REQ-015 In BUSY the counter SHALL decrement each cycle; at counter==1 the next state SHALL be IDLE with counter 0.
REQ-016 mdu_busy SHALL equal (state==BUSY): high for cycles t+1..t+MDU_CYCLES after an MDU accept at t.
REQ-017 The MDU op's own decode SHALL still appear at t+1 per REQ-010; only later ops are blocked.
REQ-018 Illegal ops SHALL flow like normal ops and never enter BUSY.
REQ-019 flush SHALL take priority over every other event: next cycle out_valid=0, state=IDLE, counter=0; input that cycle is dropped.
REQ-020 flush during BUSY SHALL abort the MDU sequence (mdu_busy=0 next cycle).

Reset
REQ-021 rst_n=0 at a rising edge SHALL set out_valid=0, alu_ctrl=0, is_mdu=0, illegal=0, mdu_busy=0, state=IDLE, counter=0.
REQ-022 Reset SHALL take priority over flush and accept; reset mid-BUSY SHALL abort to IDLE.
REQ-023 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-024 MODE=1, opcode=0x00, funct=0x22, out_ready=1 -> next cycle alu_ctrl=1, out_valid=1, illegal=0.
REQ-025 MODE=1, opcode=0x00, funct=0x18, MDU_CYCLES=4 -> decode alu_ctrl=12, is_mdu=1 at t+1; mdu_busy=1 and in_ready=0 for t+1..t+4; in_ready=1 at t+5.
REQ-026 Back-to-back 0x23 (lw), 0x0D (ori), 0x3F with out_ready=1 -> alu_ctrl 0, 3, 0 on consecutive cycles; illegal=1 only on the third.
REQ-027 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next queued op accepted the same cycle.
REQ-028 flush asserted with in_valid=1 while mdu_busy=1 -> next cycle out_valid=0, mdu_busy=0, in_ready=1.
REQ-029 MODE=0, opcode=0x2A -> alu_ctrl=0x2A, illegal=0; rst_n=0 mid-BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: MIPS opcode/funct to ALU-control decoder with a single
// registered output slot and a multiply/divide occupancy tracker.
module alu_ctrl_unit #(
    parameter int MODE       = 1,
    parameter int CTRLW      = 6,
    parameter int MDU_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTRLW-1:0] alu_ctrl,
    output logic             is_mdu,
    output logic             illegal,
    output logic             mdu_busy
);
    localparam int CW = $clog2(MDU_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [CTRLW-1:0] ctrl_q, ctrl_d;
    logic             mdu_q, mdu_d;
    logic             ill_q, ill_d;

    logic [3:0]       code;
    logic             code_ill;
    logic [CTRLW-1:0] dec_ctrl;
    logic             dec_ill;
    logic             dec_mdu;
    logic             accept;

    // MIPS decode: R-type by funct, everything else by opcode
    always_comb begin
        code     = 4'd0;
        code_ill = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20, 6'h21: code = 4'd0;
                6'h22, 6'h23: code = 4'd1;
                6'h24:        code = 4'd2;
                6'h25:        code = 4'd3;
                6'h26:        code = 4'd4;
                6'h27:        code = 4'd5;
                6'h2A:        code = 4'd6;
                6'h2B:        code = 4'd7;
                6'h00:        code = 4'd8;
                6'h02:        code = 4'd9;
                6'h03:        code = 4'd10;
                6'h18, 6'h19: code = 4'd12;
                6'h1A, 6'h1B: code = 4'd13;
                default:      code_ill = 1'b1;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09,
                6'h23, 6'h2B: code = 4'd0;
                6'h04, 6'h05: code = 4'd1;
                6'h0C:        code = 4'd2;
                6'h0D:        code = 4'd3;
                6'h0E:        code = 4'd4;
                6'h0A:        code = 4'd6;
                6'h0B:        code = 4'd7;
                6'h0F:        code = 4'd11;
                default:      code_ill = 1'b1;
            endcase
        end
    end

    // Select legacy pass-through or the MIPS decode result
    always_comb begin
        if (MODE == 0) begin
            dec_ctrl = CTRLW'(opcode);
            dec_ill  = 1'b0;
            dec_mdu  = 1'b0;
        end else begin
            dec_ctrl = CTRLW'(code);
            dec_ill  = code_ill;
            dec_mdu  = !code_ill && (code == 4'd12 || code == 4'd13);
        end
    end

    assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Next-state for output slot and MDU occupancy; flush wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        mdu_d   = mdu_q;
        ill_d   = ill_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                valid_d = 1'b1;
                ctrl_d  = dec_ctrl;
                mdu_d   = dec_mdu;
                ill_d   = dec_ill;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept && dec_mdu) begin
                        state_d = BUSY;
                        cnt_d   = CW'(MDU_CYCLES);
                    end
                end
                BUSY: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            mdu_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            mdu_q   <= mdu_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid = valid_q;
    assign alu_ctrl  = ctrl_q;
    assign is_mdu    = mdu_q;
    assign illegal   = ill_q;
    assign mdu_busy  = (state_q == BUSY);
endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: table vectors, directed corner sequences and random
// stimulus against a cycle-level reference model, MODE=1 and MODE=0.
module tb_alu_ctrl_unit;
    localparam int MDUC = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       flush;
    logic       out_ready;

    logic       ir [2];
    logic       ov [2];
    logic [5:0] ac [2];
    logic       md [2];
    logic       il [2];
    logic       mb [2];

    int errors = 0;
    int checks = 0;

    alu_ctrl_unit #(.MODE(1), .CTRLW(6), .MDU_CYCLES(MDUC)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .opcode(opcode), .funct(funct), .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .alu_ctrl(ac[1]),
        .is_mdu(md[1]), .illegal(il[1]), .mdu_busy(mb[1])
    );

    alu_ctrl_unit #(.MODE(0), .CTRLW(6), .MDU_CYCLES(32)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .opcode(opcode), .funct(funct), .flush(flush),
        .out_valid(ov[0]), .out_ready(out_ready), .alu_ctrl(ac[0]),
        .is_mdu(md[0]), .illegal(il[0]), .mdu_busy(mb[0])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference decode tables: -1 marks an unlisted encoding
    int rt [64];
    int it [64];

    typedef struct {
        bit v;
        int ctrl;
        bit mdu;
        bit ill;
        int left;
    } mstate_t;
    mstate_t m [2];

    function automatic void ref_dec(input int mode, input int op,
                                    input int fn, output int c,
                                    output bit ill, output bit mdu);
        if (mode == 0) begin
            c   = op;
            ill = 0;
            mdu = 0;
        end else begin
            c   = (op == 0) ? rt[fn] : it[op];
            ill = (c < 0);
            if (ill) c = 0;
            mdu = (c == 12 || c == 13);
        end
    endfunction

    function automatic bit m_ready(input int i);
        return m[i].left == 0 && (!m[i].v || out_ready);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit rdy [2];
        int c;
        bit ill, mdu;
        for (int i = 0; i < 2; i++) rdy[i] = m_ready(i);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m[i] = '{0, 0, 0, 0, 0};
            end else if (flush) begin
                m[i].v    = 0;
                m[i].left = 0;
            end else begin
                if (m[i].left > 0) m[i].left--;
                if (in_valid && rdy[i]) begin
                    ref_dec(i, int'(opcode), int'(funct), c, ill, mdu);
                    m[i].v    = 1;
                    m[i].ctrl = c;
                    m[i].ill  = ill;
                    m[i].mdu  = mdu;
                    if (mdu) m[i].left = MDUC;
                end else if (out_ready) begin
                    m[i].v = 0;
                end
            end
        end
    endtask

    // one clock: compare against model at negedge, advance model at posedge
    task automatic tick();
        int act, exp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            act = {ov[i], ac[i], md[i], il[i], mb[i], ir[i]};
            exp = {m[i].v, 6'(m[i].ctrl), m[i].mdu, m[i].ill,
                   m[i].left > 0, m_ready(i)};
            chk(i == 1 ? "model_mode1" : "model_mode0", act, exp);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input int op, input int fn);
        in_valid = v;
        opcode   = 6'(op);
        funct    = 6'(fn);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int op;
        int fn;
        int ctrl;
        bit ill;
        bit mdu;
    } vec_t;

    vec_t vt [$];

    initial begin
        for (int i = 0; i < 64; i++) begin
            rt[i] = -1;
            it[i] = -1;
        end
        rt[6'h20] = 0;  rt[6'h21] = 0;  rt[6'h22] = 1;  rt[6'h23] = 1;
        rt[6'h24] = 2;  rt[6'h25] = 3;  rt[6'h26] = 4;  rt[6'h27] = 5;
        rt[6'h2A] = 6;  rt[6'h2B] = 7;  rt[6'h00] = 8;  rt[6'h02] = 9;
        rt[6'h03] = 10; rt[6'h18] = 12; rt[6'h19] = 12; rt[6'h1A] = 13;
        rt[6'h1B] = 13;
        it[6'h08] = 0;  it[6'h09] = 0;  it[6'h23] = 0;  it[6'h2B] = 0;
        it[6'h04] = 1;  it[6'h05] = 1;  it[6'h0C] = 2;  it[6'h0D] = 3;
        it[6'h0E] = 4;  it[6'h0A] = 6;  it[6'h0B] = 7;  it[6'h0F] = 11;

        vt = '{
            '{6'h00, 6'h22, 1,  0, 0},
            '{6'h00, 6'h18, 12, 0, 1},
            '{6'h23, 6'h3F, 0,  0, 0},
            '{6'h0D, 6'h00, 3,  0, 0},
            '{6'h3F, 6'h00, 0,  1, 0},
            '{6'h0F, 6'h11, 11, 0, 0},
            '{6'h00, 6'h03, 10, 0, 0},
            '{6'h00, 6'h2A, 6,  0, 0},
            '{6'h00, 6'h1B, 13, 0, 1},
            '{6'h00, 6'h01, 0,  1, 0},
            '{6'h0B, 6'h00, 7,  0, 0},
            '{6'h04, 6'h00, 1,  0, 0},
            '{6'h00, 6'h27, 5,  0, 0}
        };

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0);
        m[0] = '{0, 0, 0, 0, 0};
        m[1] = '{0, 0, 0, 0, 0};
        do_reset();

        chk("reset_out_valid", int'(ov[1]), 0);
        chk("reset_mdu_busy", int'(mb[1]), 0);
        chk("ready_after_reset", int'(ir[1]), 1);

        // table vectors, one op at a time, waiting out MDU occupancy
        foreach (vt[k]) begin
            drive(1, vt[k].op, vt[k].fn);
            tick();
            drive(0, 0, 0);
            chk($sformatf("vec%0d_ctrl", k), int'(ac[1]), vt[k].ctrl);
            chk($sformatf("vec%0d_ill", k), int'(il[1]), int'(vt[k].ill));
            chk($sformatf("vec%0d_mdu", k), int'(md[1]), int'(vt[k].mdu));
            chk($sformatf("vec%0d_valid", k), int'(ov[1]), 1);
            for (int w = 0; w < 10 && !m_ready(1); w++) tick();
            tick();
        end

        // MULT occupancy with a queued op behind it
        drive(1, 6'h00, 6'h18);
        tick();
        drive(1, 6'h00, 6'h20);
        chk("mult_ctrl", int'(ac[1]), 12);
        chk("mult_is_mdu", int'(md[1]), 1);
        for (int k = 1; k <= MDUC; k++) begin
            chk($sformatf("mult_busy_t%0d", k), int'(mb[1]), 1);
            chk($sformatf("mult_noready_t%0d", k), int'(ir[1]), 0);
            tick();
        end
        chk("mult_ready_after", int'(ir[1]), 1);
        chk("mult_idle_after", int'(mb[1]), 0);
        tick();
        drive(0, 0, 0);
        chk("queued_add_ctrl", int'(ac[1]), 0);
        tick();

        // back-to-back lw, ori, illegal
        drive(1, 6'h23, 0);
        tick();
        chk("b2b_lw_ctrl", int'(ac[1]), 0);
        chk("b2b_lw_ill", int'(il[1]), 0);
        drive(1, 6'h0D, 0);
        tick();
        chk("b2b_ori_ctrl", int'(ac[1]), 3);
        chk("b2b_ori_ill", int'(il[1]), 0);
        drive(1, 6'h3F, 0);
        tick();
        chk("b2b_bad_ctrl", int'(ac[1]), 0);
        chk("b2b_bad_ill", int'(il[1]), 1);
        chk("b2b_bad_valid", int'(ov[1]), 1);
        drive(0, 0, 0);
        tick();

        // backpressure: output held, next op queued until release
        out_ready = 1'b0;
        drive(1, 6'h0D, 0);
        tick();
        drive(1, 6'h0E, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ctrl", k), int'(ac[1]), 3);
            chk($sformatf("stall%0d_valid", k), int'(ov[1]), 1);
            chk($sformatf("stall%0d_ready", k), int'(ir[1]), 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", int'(ir[1]), 1);
        tick();
        drive(0, 0, 0);
        chk("release_ctrl", int'(ac[1]), 4);
        tick();

        // flush during BUSY with a pending input
        drive(1, 6'h00, 6'h1A);
        tick();
        drive(1, 6'h00, 6'h24);
        tick();
        chk("pre_flush_busy", int'(mb[1]), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 0, 0);
        #1;
        chk("flush_valid", int'(ov[1]), 0);
        chk("flush_busy", int'(mb[1]), 0);
        chk("flush_ready", int'(ir[1]), 1);
        tick();

        // legacy pass-through
        drive(1, 6'h2A, 0);
        tick();
        drive(0, 0, 0);
        chk("legacy_ctrl", int'(ac[0]), 6'h2A);
        chk("legacy_ill", int'(il[0]), 0);
        chk("legacy_busy", int'(mb[0]), 0);
        tick();

        // reset in the middle of BUSY
        drive(1, 6'h00, 6'h19);
        tick();
        drive(0, 0, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy_outs",
            int'({ov[1], ac[1], md[1], il[1], mb[1]}), 0);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = ($urandom_range(0, 1) == 0) ? 6'h00
                                                    : 6'($urandom);
            funct     = 6'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
